// File: rtl/prv32_ex_mem_stage.sv
// EX/MEM pipeline register for the prv32 core: resolves branches, drives a one-cycle
// redirect, squashes the single wrong-path instruction behind it, and keeps branch statistics.
module prv32_ex_mem_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      alu_r,
  input  logic             cf,
  input  logic             zf,
  input  logic             vf,
  input  logic             sf,
  input  logic [31:0]      target,
  input  logic [31:0]      pc_plus4,
  input  logic [31:0]      rs2_data,
  input  logic [4:0]       rd,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [2:0]       funct3,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  output logic             out_valid,
  output logic [31:0]      out_alu_r,
  output logic [31:0]      out_rs2_data,
  output logic [31:0]      out_pc_plus4,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  logic             cond;
  logic             live;
  logic             take;

  logic             valid_q,      valid_d;
  logic [31:0]      alu_r_q,      alu_r_d;
  logic [31:0]      rs2_data_q,   rs2_data_d;
  logic [31:0]      pc_plus4_q,   pc_plus4_d;
  logic [4:0]       rd_q,         rd_d;
  logic             reg_write_q,  reg_write_d;
  logic             mem_read_q,   mem_read_d;
  logic             mem_write_q,  mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             redirect_q,   redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             taken_q,      taken_d;
  logic             squash_q,     squash_d;
  logic [CNT_W-1:0] br_count_q,   br_count_d;
  logic [CNT_W-1:0] taken_cnt_q,  taken_cnt_d;

  // Branch condition from the a-b flags: cf=1 means no borrow, i.e. a >= b unsigned.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = zf;
      3'b001:  cond = ~zf;
      3'b100:  cond = sf ^ vf;
      3'b101:  cond = ~(sf ^ vf);
      3'b110:  cond = ~cf;
      3'b111:  cond = cf;
      default: cond = 1'b0;
    endcase
  end

  assign live = in_valid & ~squash_q;
  assign take = live & (is_jump | (is_branch & cond));

  // Flush beats stall beats a normal load; reset is handled in the register block.
  always_comb begin
    valid_d       = valid_q;
    alu_r_d       = alu_r_q;
    rs2_data_d    = rs2_data_q;
    pc_plus4_d    = pc_plus4_q;
    rd_d          = rd_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    taken_d       = taken_q;
    squash_d      = squash_q;
    br_count_d    = br_count_q;
    taken_cnt_d   = taken_cnt_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      redirect_d   = 1'b0;
      taken_d      = 1'b0;
      squash_d     = 1'b0;
    end else if (stall) begin
      redirect_d = 1'b0;
    end else begin
      valid_d      = live;
      alu_r_d      = alu_r;
      rs2_data_d   = rs2_data;
      pc_plus4_d   = pc_plus4;
      rd_d         = rd;
      reg_write_d  = reg_write & live;
      mem_read_d   = mem_read & live;
      mem_write_d  = mem_write & live;
      mem_to_reg_d = mem_to_reg & live;
      redirect_d   = take;
      taken_d      = take;
      squash_d     = take;
      if (take) redirect_pc_d = target;
      if (live & is_branch) br_count_d = br_count_q + CNT_W'(1);
      if (live & is_branch & cond) taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      alu_r_q       <= '0;
      rs2_data_q    <= '0;
      pc_plus4_q    <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      taken_q       <= 1'b0;
      squash_q      <= 1'b0;
      br_count_q    <= '0;
      taken_cnt_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      alu_r_q       <= alu_r_d;
      rs2_data_q    <= rs2_data_d;
      pc_plus4_q    <= pc_plus4_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      taken_q       <= taken_d;
      squash_q      <= squash_d;
      br_count_q    <= br_count_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_r      = alu_r_q;
  assign out_rs2_data   = rs2_data_q;
  assign out_pc_plus4   = pc_plus4_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_mem_to_reg = mem_to_reg_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign taken          = taken_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_prv32_ex_mem_stage.sv
// Bench for prv32_ex_mem_stage: fixed vector table, hand-built stall/flush/reset/wrap
// sequences, then random traffic against an operand-level reference model.
module tb_prv32_ex_mem_stage;

  localparam int CW = 4;
  localparam int NV = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, inValid, stall, flush;
  logic [31:0] aluR, target, pc4, rs2;
  logic cfI, zfI, vfI, sfI;
  logic [4:0] rd;
  logic isBranch, isJump;
  logic [2:0] f3;
  logic regWrite, memRead, memWrite, memToReg;
  logic [31:0] opA, opB;

  logic oValid, oRw, oMr, oMw, oMtr, oRedir, oTaken;
  logic [31:0] oAlu, oRs2, oPc4, oRpc;
  logic [4:0] oRd;
  logic [CW-1:0] oBr, oTk;

  logic mValid, mRw, mMr, mMw, mMtr, mRedir, mTaken, mSquash;
  logic [31:0] mAlu, mRs2, mPc4, mRpc;
  logic [4:0] mRd;
  logic [CW-1:0] mBr, mTk;

  int checks = 0;
  int failures = 0;

  prv32_ex_mem_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .stall(stall), .flush(flush),
    .alu_r(aluR), .cf(cfI), .zf(zfI), .vf(vfI), .sf(sfI),
    .target(target), .pc_plus4(pc4), .rs2_data(rs2), .rd(rd),
    .is_branch(isBranch), .is_jump(isJump), .funct3(f3),
    .reg_write(regWrite), .mem_read(memRead), .mem_write(memWrite), .mem_to_reg(memToReg),
    .out_valid(oValid), .out_alu_r(oAlu), .out_rs2_data(oRs2), .out_pc_plus4(oPc4),
    .out_rd(oRd), .out_reg_write(oRw), .out_mem_read(oMr), .out_mem_write(oMw),
    .out_mem_to_reg(oMtr), .redirect(oRedir), .redirect_pc(oRpc), .taken(oTaken),
    .br_count(oBr), .taken_count(oTk)
  );

  typedef struct {
    logic inValid, isBranch, isJump, regWrite;
    logic [2:0] f3;
    logic [31:0] a, b, target;
    logic eValid, eRegWrite, eTaken, eRedirect;
    logic [31:0] eRpc;
    logic [CW-1:0] eBr, eTk;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mkVec(input logic v, br, jp, rw, input logic [2:0] f,
                                 input logic [31:0] a, b, tg,
                                 input logic ev, erw, et, er, input logic [31:0] erpc,
                                 input logic [CW-1:0] ebr, etk);
    vec_t r;
    r.inValid = v; r.isBranch = br; r.isJump = jp; r.regWrite = rw; r.f3 = f;
    r.a = a; r.b = b; r.target = tg;
    r.eValid = ev; r.eRegWrite = erw; r.eTaken = et; r.eRedirect = er;
    r.eRpc = erpc; r.eBr = ebr; r.eTk = etk;
    return r;
  endfunction

  // The branch decision as the ISA states it, directly on the operands.
  function automatic logic branchResolves(input logic [2:0] f, input logic [31:0] a, b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Plays the ALU: derive the a-b flags the stage sees on its pins.
  task automatic setOperands(input logic [31:0] a, b);
    logic [32:0] d;
    d = {1'b0, a} + {1'b0, ~b} + 33'd1;
    opA = a;
    opB = b;
    zfI = (d[31:0] == 32'd0);
    cfI = d[32];
    sfI = d[31];
    vfI = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic randData();
    aluR = $urandom; rs2 = $urandom; pc4 = $urandom; rd = 5'($urandom);
    regWrite = 1'($urandom); memRead = 1'($urandom);
    memWrite = 1'($urandom); memToReg = 1'($urandom);
  endtask

  task automatic setInstr(input logic v, br, jp, input logic [2:0] f,
                          input logic [31:0] a, b, tg, input logic rw);
    randData();
    inValid = v; isBranch = br; isJump = jp; f3 = f; target = tg; regWrite = rw;
    setOperands(a, b);
  endtask

  task automatic modelStep();
    logic c, live, take;
    if (rst) begin
      mValid = 0; mRw = 0; mMr = 0; mMw = 0; mMtr = 0; mRedir = 0; mTaken = 0; mSquash = 0;
      mAlu = 0; mRs2 = 0; mPc4 = 0; mRpc = 0; mRd = 0; mBr = 0; mTk = 0;
    end else if (flush) begin
      mValid = 0; mRw = 0; mMr = 0; mMw = 0; mMtr = 0; mRedir = 0; mTaken = 0; mSquash = 0;
    end else if (stall) begin
      mRedir = 0;
    end else begin
      c = branchResolves(f3, opA, opB);
      live = inValid && !mSquash;
      take = live && (isJump || (isBranch && c));
      mValid = live; mAlu = aluR; mRs2 = rs2; mPc4 = pc4; mRd = rd;
      mRw = regWrite && live; mMr = memRead && live;
      mMw = memWrite && live; mMtr = memToReg && live;
      mTaken = take; mRedir = take;
      if (take) mRpc = target;
      if (live && isBranch) begin
        mBr = mBr + CW'(1);
        if (c) mTk = mTk + CW'(1);
      end
      mSquash = take;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", 32'(oValid), 32'(mValid));
    checkVal("out_alu_r", oAlu, mAlu);
    checkVal("out_rs2_data", oRs2, mRs2);
    checkVal("out_pc_plus4", oPc4, mPc4);
    checkVal("out_rd", 32'(oRd), 32'(mRd));
    checkVal("out_reg_write", 32'(oRw), 32'(mRw));
    checkVal("out_mem_read", 32'(oMr), 32'(mMr));
    checkVal("out_mem_write", 32'(oMw), 32'(mMw));
    checkVal("out_mem_to_reg", 32'(oMtr), 32'(mMtr));
    checkVal("redirect", 32'(oRedir), 32'(mRedir));
    checkVal("redirect_pc", oRpc, mRpc);
    checkVal("taken", 32'(oTaken), 32'(mTaken));
    checkVal("br_count", 32'(oBr), 32'(mBr));
    checkVal("taken_count", 32'(oTk), 32'(mTk));
  endtask

  // Inputs are set at the falling edge; outputs are sampled at the next falling edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1; stall = 0; flush = 0;
    setInstr(0, 0, 0, 3'b000, 0, 0, 0, 0);
    applyStimulus();
    rst = 0;
  endtask

  initial begin
    rst = 1; inValid = 0; stall = 0; flush = 0; isBranch = 0; isJump = 0; f3 = 0;
    target = 0; aluR = 0; pc4 = 0; rs2 = 0; rd = 0;
    regWrite = 0; memRead = 0; memWrite = 0; memToReg = 0;
    setOperands(0, 0);
    mSquash = 0; mBr = 0; mTk = 0;

    //                v  br jp rw f3      a             b      target        ev erw et er rpc          br  tk
    vecs[0]  = mkVec(1, 1, 0, 0, 3'b000, 32'd5,        32'd5, 32'h100, 1, 0, 1, 1, 32'h100, 4'd1, 4'd1);
    vecs[1]  = mkVec(1, 0, 0, 1, 3'b000, 32'd9,        32'd4, 32'h999, 0, 0, 0, 0, 32'h100, 4'd1, 4'd1);
    vecs[2]  = mkVec(1, 1, 0, 0, 3'b110, 32'd7,        32'd3, 32'h150, 1, 0, 0, 0, 32'h100, 4'd2, 4'd1);
    vecs[3]  = mkVec(1, 1, 0, 0, 3'b111, 32'd7,        32'd3, 32'h200, 1, 0, 1, 1, 32'h200, 4'd3, 4'd2);
    vecs[4]  = mkVec(0, 0, 0, 1, 3'b000, 32'd0,        32'd0, 32'h0,   0, 0, 0, 0, 32'h200, 4'd3, 4'd2);
    vecs[5]  = mkVec(1, 0, 1, 1, 3'b010, 32'd1,        32'd2, 32'h300, 1, 1, 1, 1, 32'h300, 4'd3, 4'd2);
    vecs[6]  = mkVec(1, 0, 0, 1, 3'b000, 32'd3,        32'd3, 32'h0,   0, 0, 0, 0, 32'h300, 4'd3, 4'd2);
    vecs[7]  = mkVec(1, 0, 0, 1, 3'b000, 32'd3,        32'd3, 32'h0,   1, 1, 0, 0, 32'h300, 4'd3, 4'd2);
    vecs[8]  = mkVec(1, 1, 0, 0, 3'b001, 32'd1,        32'd2, 32'h400, 1, 0, 1, 1, 32'h400, 4'd4, 4'd3);
    vecs[9]  = mkVec(1, 1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h480, 0, 0, 0, 0, 32'h400, 4'd4, 4'd3);
    vecs[10] = mkVec(1, 1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h500, 1, 0, 1, 1, 32'h500, 4'd5, 4'd4);
    vecs[11] = mkVec(0, 0, 0, 0, 3'b000, 32'd0,        32'd0, 32'h0,   0, 0, 0, 0, 32'h500, 4'd5, 4'd4);
    vecs[12] = mkVec(1, 1, 0, 0, 3'b010, 32'd0,        32'd0, 32'h600, 1, 0, 0, 0, 32'h500, 4'd6, 4'd4);

    @(negedge clk);
    doReset();
    checkVal("reset_valid", 32'(oValid), 32'd0);
    checkVal("reset_br_count", 32'(oBr), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      setInstr(vecs[i].inValid, vecs[i].isBranch, vecs[i].isJump, vecs[i].f3,
               vecs[i].a, vecs[i].b, vecs[i].target, vecs[i].regWrite);
      applyStimulus();
      checkVal($sformatf("tbl%0d_valid", i), 32'(oValid), 32'(vecs[i].eValid));
      checkVal($sformatf("tbl%0d_reg_write", i), 32'(oRw), 32'(vecs[i].eRegWrite));
      checkVal($sformatf("tbl%0d_taken", i), 32'(oTaken), 32'(vecs[i].eTaken));
      checkVal($sformatf("tbl%0d_redirect", i), 32'(oRedir), 32'(vecs[i].eRedirect));
      checkVal($sformatf("tbl%0d_redirect_pc", i), oRpc, vecs[i].eRpc);
      checkVal($sformatf("tbl%0d_br_count", i), 32'(oBr), 32'(vecs[i].eBr));
      checkVal($sformatf("tbl%0d_taken_count", i), 32'(oTk), 32'(vecs[i].eTk));
    end

    $display("[TB] taken branch held by a three-cycle stall");
    doReset();
    setInstr(1, 1, 0, 3'b000, 32'd8, 32'd8, 32'h640, 0);
    applyStimulus();
    checkVal("stall_pre_redirect", 32'(oRedir), 32'd1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      setInstr(1, 0, 0, 3'b000, 32'd1, 32'd1, 32'h0, 1);
      applyStimulus();
      checkVal($sformatf("stall%0d_redirect", i), 32'(oRedir), 32'd0);
      checkVal($sformatf("stall%0d_taken", i), 32'(oTaken), 32'd1);
      checkVal($sformatf("stall%0d_redirect_pc", i), oRpc, 32'h640);
    end
    stall = 0;
    setInstr(1, 0, 0, 3'b000, 32'd1, 32'd1, 32'h0, 1);
    applyStimulus();
    checkVal("post_stall_squashed_valid", 32'(oValid), 32'd0);
    setInstr(1, 0, 0, 3'b000, 32'd1, 32'd1, 32'h0, 1);
    applyStimulus();
    checkVal("post_stall_next_valid", 32'(oValid), 32'd1);

    $display("[TB] stall and flush together on a store");
    setInstr(1, 0, 0, 3'b000, 32'd1, 32'd2, 32'h0, 0);
    memWrite = 1;
    stall = 1; flush = 1;
    applyStimulus();
    checkVal("flush_stall_valid", 32'(oValid), 32'd0);
    checkVal("flush_stall_mem_write", 32'(oMw), 32'd0);
    stall = 0; flush = 0;

    $display("[TB] reset during stall with a pending squash");
    setInstr(1, 1, 0, 3'b111, 32'd9, 32'd2, 32'h700, 0);
    applyStimulus();
    rst = 1; stall = 1;
    setInstr(1, 0, 1, 3'b000, 32'd0, 32'd0, 32'h800, 1);
    applyStimulus();
    checkVal("rst_stall_valid", 32'(oValid), 32'd0);
    checkVal("rst_stall_redirect_pc", oRpc, 32'd0);
    checkVal("rst_stall_br_count", 32'(oBr), 32'd0);
    checkVal("rst_stall_taken_count", 32'(oTk), 32'd0);
    rst = 0; stall = 0;
    setInstr(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 1);
    applyStimulus();
    checkVal("rst_cleared_squash_valid", 32'(oValid), 32'd1);

    $display("[TB] branch counter wrap");
    doReset();
    for (int i = 0; i < 16; i++) begin
      setInstr(1, 1, 0, 3'b000, 32'd1, 32'd2, 32'h900, 0);
      applyStimulus();
      if (i == 14) checkVal("wrap_br_count_max", 32'(oBr), 32'd15);
    end
    checkVal("wrap_br_count_zero", 32'(oBr), 32'd0);
    checkVal("wrap_taken_count", 32'(oTk), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      int kind;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      kind = $urandom_range(0, 3);
      setInstr(1'($urandom_range(0, 9) < 7), kind == 1 || kind == 3, kind == 2,
               3'($urandom), a, b, $urandom, 1'($urandom));
      rst = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      applyStimulus();
    end
    rst = 0; flush = 0; stall = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
